// File: rtl/fetch_if.sv
// Fetch <-> ROM/decode/redirect bundle. master = fetch unit side, slave = environment side.
interface fetch_if #(parameter int N = 64);
  logic [N-1:0] PCBranch_F;
  logic         PCSrc_F;
  logic [5:0]   imem_addr_F;
  logic [31:0]  imem_q;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;
  logic         ready_D;
  logic         halted;

  modport master (
    input  PCBranch_F, PCSrc_F, imem_q, ready_D,
    output imem_addr_F, instr_D, pc_D, valid_D, halted
  );

  modport slave (
    output PCBranch_F, PCSrc_F, imem_q, ready_D,
    input  imem_addr_F, instr_D, pc_D, valid_D, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/FLUSH/HALT sequencer feeding decode through a valid/ready register.
// Optional accepted-instruction counter port fetch_cnt when FETCH_CNT_EN is defined.
module fetch_unit #(
  parameter int N = 64
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_e;

  state_e       state_q;
  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         halted_q;

  logic advance;
  logic out_of_range;
  logic xfer;

  assign advance      = ~valid_q | bus.ready_D;
  assign xfer         = valid_q & bus.ready_D;
  // ROM holds 64 words; anything above byte address 0xFF is off the end.
  assign out_of_range = |pc_q[N-1:8];

  assign bus.imem_addr_F = pc_q[7:2];
  assign bus.instr_D     = instr_q;
  assign bus.pc_D        = pc_d_q;
  assign bus.valid_D     = valid_q;
  assign bus.halted      = halted_q;

  // Redirect targets are forced word-aligned; the dropped low bits are not a fault.
  logic unused_lowbits;
  assign unused_lowbits = ^bus.PCBranch_F[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      pc_d_q   <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (bus.PCSrc_F) begin
      pc_q     <= {bus.PCBranch_F[N-1:2], 2'b00};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      state_q  <= FLUSH;
    end else begin
      case (state_q)
        BOOT:  state_q <= RUN;
        FLUSH: state_q <= RUN;
        RUN: begin
          if (advance) begin
            if (out_of_range) begin
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              instr_q <= bus.imem_q;
              pc_d_q  <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + N'(4);
            end
          end
        end
        HALT: begin
          if (bus.ready_D) valid_q <= 1'b0;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q;
  assign fetch_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 32'd1;
  end
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, instr) stream queued on redirect/reset, popped on each transfer.
module tb_fetch_unit;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.N(N)) bus();
  logic [31:0] rom [64];
  assign bus.imem_q = rom[bus.imem_addr_F];

`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt;
  fetch_unit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus), .fetch_cnt(fetch_cnt));
`else
  fetch_unit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic [N-1:0] pc;
    logic [31:0]  instr;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          model_cnt = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [N-1:0] prev_pc;
  logic [31:0]  prev_instr;
  int          redir_age = 0;
  bit          redir_in_range = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: after a (re)start at byte address t, decode sees every word t, t+4, ... below 0x100, in order.
  task automatic load_stream(input logic [N-1:0] tgt);
    logic [N-1:0] a;
    exp_t e;
    sb.delete();
    a = tgt & ~(N'(3));
    while (a < N'(256)) begin
      e.pc = a;
      e.instr = rom[a[7:2]];
      sb.push_back(e);
      a = a + N'(4);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [N-1:0] tgt);
    bus.PCSrc_F = 1'b1;
    bus.PCBranch_F = tgt;
    step();
    bus.PCSrc_F = 1'b0;
    load_stream(tgt);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (!bus.valid_D && n < budget) begin
      step();
      n++;
    end
    if (!bus.valid_D) chk({nm, "_timeout"}, 64'(bus.valid_D), 64'd1);
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin
      step();
      n++;
    end
    chk(nm, 64'(bus.halted), 64'd1);
  endtask

  // Monitor: inputs are settled by the negedge, so valid & ready here means a transfer on the next edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      redir_age = 0;
    end else if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.valid_D), 64'd1);
        chk("stall_pc", bus.pc_D, prev_pc);
        chk("stall_instr", 64'(bus.instr_D), 64'(prev_instr));
      end
      if (redir_age == 1 || redir_age == 2) chk("flush_bubble", 64'(bus.valid_D), 64'd0);
      if (redir_age == 3 && redir_in_range) chk("redirect_latency", 64'(bus.valid_D), 64'd1);
      if (bus.halted) begin
        chk("halt_valid", 64'(bus.valid_D), 64'd0);
        chk("halt_stream_done", 64'(sb.size()), 64'd0);
      end
`ifdef FETCH_CNT_EN
      chk("fetch_cnt", 64'(fetch_cnt), 64'(model_cnt));
`endif
      if (bus.valid_D && bus.ready_D) begin
        model_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_xfer_pc", bus.pc_D, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_pc", bus.pc_D, e.pc);
          chk("xfer_instr", 64'(bus.instr_D), 64'(e.instr));
        end
      end
      prev_stall = bus.valid_D && !bus.ready_D && !bus.PCSrc_F;
      prev_pc = bus.pc_D;
      prev_instr = bus.instr_D;
      if (bus.PCSrc_F) begin
        redir_age = 1;
        redir_in_range = (bus.PCBranch_F < N'(256));
      end else if (redir_age != 0 && redir_age < 3) begin
        redir_age++;
      end else begin
        redir_age = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h8B0F0101;
    reset = 1'b1;
    bus.PCSrc_F = 1'b0;
    bus.PCBranch_F = '0;
    bus.ready_D = 1'b1;
    step();
    step();
    chk("rst_valid", 64'(bus.valid_D), 64'd0);
    chk("rst_instr", 64'(bus.instr_D), 64'd0);
    chk("rst_pc_D", bus.pc_D, 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_imem_addr", 64'(bus.imem_addr_F), 64'd0);
`ifdef FETCH_CNT_EN
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
`endif

    // Boot bubble, then back-to-back fetch from address 0.
    reset = 1'b0;
    load_stream('0);
    model_cnt = 0;
    mon_en = 1'b1;
    step();
    chk("boot_bubble", 64'(bus.valid_D), 64'd0);
    step();
    chk("first_valid", 64'(bus.valid_D), 64'd1);
    chk("first_instr", 64'(bus.instr_D), 64'h8B0F0101);
    chk("first_pc", bus.pc_D, 64'd0);
    step();
    chk("seq_pc4", bus.pc_D, 64'd4);
    step();
    chk("seq_pc8", bus.pc_D, 64'd8);

    // Three-cycle stall on pc_D = 8.
    bus.ready_D = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_pc8", bus.pc_D, 64'd8);
    end
    bus.ready_D = 1'b1;
    step();
    chk("after_stall_pc12", bus.pc_D, 64'd12);

    // Redirect while an instruction is held: it is dropped, low target bits ignored.
    bus.ready_D = 1'b0;
    step();
    do_redirect(64'h23);
    chk("redir_drop_valid", 64'(bus.valid_D), 64'd0);
    bus.ready_D = 1'b1;
    step();
    step();
    chk("redir_valid", 64'(bus.valid_D), 64'd1);
    chk("redir_pc20", bus.pc_D, 64'h20);

    // Run off the end of the ROM into HALT, then restart from 0.
    wait_halt("halt_reached", 300);
    chk("halt_valid_low", 64'(bus.valid_D), 64'd0);
    chk("halt_last_pc", bus.pc_D, 64'hFC);
    do_redirect(64'h0);
    chk("unhalt", 64'(bus.halted), 64'd0);
    step();
    step();
    chk("resume_valid", 64'(bus.valid_D), 64'd1);
    chk("resume_pc0", bus.pc_D, 64'd0);

    // Random backpressure and redirects, including far out-of-range targets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.ready_D = ($urandom_range(0, 3) != 0);
      if ((bus.halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 39) == 0) begin
        logic [N-1:0] tgt;
        if ($urandom_range(0, 7) == 0) tgt = {32'h1, $urandom};
        else tgt = N'($urandom_range(0, 259));
        do_redirect(tgt);
      end else begin
        step();
      end
    end

    // Reset during a stall with a redirect pending overrides everything.
    bus.ready_D = 1'b0;
    do_redirect(64'h10);
    wait_valid("pre_reset", 10);
    step();
    bus.PCSrc_F = 1'b1;
    bus.PCBranch_F = 64'h40;
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 64'(bus.valid_D), 64'd0);
    chk("mid_rst_instr", 64'(bus.instr_D), 64'd0);
    chk("mid_rst_pc_D", bus.pc_D, 64'd0);
    chk("mid_rst_halted", 64'(bus.halted), 64'd0);
    chk("mid_rst_imem_addr", 64'(bus.imem_addr_F), 64'd0);
`ifdef FETCH_CNT_EN
    chk("mid_rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
`endif
    reset = 1'b0;
    bus.PCSrc_F = 1'b0;
    bus.ready_D = 1'b1;
    load_stream('0);
    model_cnt = 0;
    step();
    chk("reboot_bubble", 64'(bus.valid_D), 64'd0);
    step();
    chk("reboot_pc0", bus.pc_D, 64'd0);
    for (int i = 0; i < 10; i++) step();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 64: width of program counter and branch target.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PCBranch_F  input  N  redirect target address, byte address.
REQ-005 PCSrc_F  input  1  redirect request; target sampled on the same edge.
REQ-006 imem_addr_F  output  6  word address to instruction ROM, combinational = pc[7:2].
REQ-007 imem_q  input  32  instruction word returned combinationally by ROM for imem_addr_F.
REQ-008 instr_D  output  32  registered instruction presented to decode.
REQ-009 pc_D  output  N  registered byte address of instr_D.
REQ-010 valid_D  output  1  instr_D/pc_D hold a live instruction.
REQ-011 ready_D  input  1  decode accepts the instruction this cycle.
REQ-012 halted  output  1  high while state = HALT.
REQ-013 fetch_cnt  output  32  accepted-instruction count; present only with FETCH_CNT_EN.

Function
REQ-014 States SHALL be BOOT, RUN, FLUSH, HALT; internal pc register width N.
REQ-015 Handshake: transfer occurs on an edge where valid_D & ready_D; instr_D/pc_D SHALL stay stable while valid_D & ~ready_D.
REQ-016 advance = ~valid_D | ready_D; only in RUN with advance SHALL the unit capture imem_q->instr_D, pc->pc_D, set valid_D, and set pc <= pc + 4 (mod 2^N).
REQ-017 In RUN with ~advance, pc, instr_D, pc_D, valid_D SHALL hold (stall).
REQ-018 BOOT: entered on reset; exits to RUN after one cycle with no capture (one-cycle bubble).
REQ-019 Redirect (PCSrc_F=1) in any state SHALL set pc <= {PCBranch_F[N-1:2], 2'b00}, clear valid_D, go to FLUSH; redirect takes priority over capture and stall.
REQ-020 An instruction held with valid_D & ~ready_D at redirect SHALL be discarded; one accepted on the same edge (ready_D=1) counts as transferred.
REQ-021 FLUSH: no capture, valid_D stays 0, next state RUN unless another redirect.
REQ-022 Out-of-range: in RUN, if pc[N-1:8] != 0 at a would-be capture, no capture SHALL occur, valid_D clears on its next transfer, state -> HALT.
REQ-023 HALT: valid_D = 0 once drained, pc held, halted = 1; only redirect leaves HALT (to FLUSH); out-of-range target re-enters HALT after FLUSH.
REQ-024 Redirect low bits PCBranch_F[1:0] SHALL be ignored; no misalignment fault.
REQ-025 Fetch latency: instruction at pc appears on instr_D one edge after capture; sustained throughput 1 instruction/cycle with ready_D=1.

Reset
REQ-026 On reset: pc = 0, state = BOOT, valid_D = 0, instr_D = 0, pc_D = 0, halted = 0, fetch_cnt = 0.
REQ-027 Reset mid-operation SHALL override redirect, stall and capture on that edge; held instruction discarded.

Configuration
REQ-028 Macro FETCH_CNT_EN defined: fetch_cnt port and 32-bit counter exist, incrementing by 1 per transfer, wrapping 0xFFFFFFFF->0, cleared only by reset.
REQ-029 Macro FETCH_CNT_EN undefined: no fetch_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-030 Reset, ready_D=1, ROM word0=0x8B0F0101 -> cycle 1 valid_D=0 (BOOT), cycle 2 instr_D=0x8B0F0101, pc_D=0, then pc_D=4,8,12 consecutively.
REQ-031 ready_D=0 for 3 cycles while valid_D=1 at pc_D=8 -> instr_D/pc_D unchanged, next fetch pc_D=12 after ready_D returns.
REQ-032 PCSrc_F=1, PCBranch_F=0x23 while valid_D&~ready_D -> held instruction dropped, one bubble, next pc_D=0x20.
REQ-033 Sequential run to pc=0x100 -> last pc_D=0xFC, then HALT, halted=1, valid_D=0; redirect to 0x0 -> resumes with pc_D=0.
REQ-034 Assert reset during stall with redirect pending -> all outputs per REQ-026 on next cycle.
REQ-035 FETCH_CNT_EN defined, 10 transfers with 2 discarded by redirect -> fetch_cnt=10; undefined build compiles without fetch_cnt.
